// File: rtl/kb_seg_display_if.sv
// Bus between a PS/2 byte receiver and the scancode display block.
// The master side supplies bytes and modifier levels. The slave side drives the eight digit patterns.
interface kb_seg_display_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       shift;
  logic       caps;
  logic [7:0] seg0;
  logic [7:0] seg1;
  logic [7:0] seg2;
  logic [7:0] seg3;
  logic [7:0] seg4;
  logic [7:0] seg5;
  logic [7:0] seg6;
  logic [7:0] seg7;

  modport master (
    output byte_valid, byte_data, shift, caps,
    input  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7
  );

  modport slave (
    input  byte_valid, byte_data, shift, caps,
    output seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7
  );
endinterface

// File: rtl/kb_seg_display.sv
// PS/2 set-2 scancode parser with an 8-digit active-low seven-segment readout.
// The digits show the held scancode, its ASCII value and a press counter.
// The segment registers load from next-state values, so a byte accepted on one
// edge is visible in the following cycle.
module kb_seg_display (
  input  logic             clk,
  input  logic             rst,
  kb_seg_display_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic       held_q, held_d;
  logic       ext_q, ext_d;
  logic [7:0] code_q, code_d;
  logic [7:0] ascii_q, ascii_d;
  logic       ascii_vld_q, ascii_vld_d;
  logic [7:0] seg_q [8];
  logic [7:0] seg_d [8];
  logic       mk, bk, ext_c, same_key;
  logic [8:0] map;

  // Active-low hex font, dp (bit 7) off
  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
    endcase
  endfunction

  // Non-extended set-2 code to {valid, ascii}; letters uppercased when upper=1
  function automatic logic [8:0] to_ascii(input logic [7:0] code, input logic upper);
    logic [7:0] ch;
    logic       ok;
    ok = 1'b1;
    case (code)
      8'h1C: ch = 8'h61;  8'h32: ch = 8'h62;  8'h21: ch = 8'h63;  8'h23: ch = 8'h64;
      8'h24: ch = 8'h65;  8'h2B: ch = 8'h66;  8'h34: ch = 8'h67;  8'h33: ch = 8'h68;
      8'h43: ch = 8'h69;  8'h3B: ch = 8'h6A;  8'h42: ch = 8'h6B;  8'h4B: ch = 8'h6C;
      8'h3A: ch = 8'h6D;  8'h31: ch = 8'h6E;  8'h44: ch = 8'h6F;  8'h4D: ch = 8'h70;
      8'h15: ch = 8'h71;  8'h2D: ch = 8'h72;  8'h1B: ch = 8'h73;  8'h2C: ch = 8'h74;
      8'h3C: ch = 8'h75;  8'h2A: ch = 8'h76;  8'h1D: ch = 8'h77;  8'h22: ch = 8'h78;
      8'h35: ch = 8'h79;  8'h1A: ch = 8'h7A;
      8'h45: ch = 8'h30;  8'h16: ch = 8'h31;  8'h1E: ch = 8'h32;  8'h26: ch = 8'h33;
      8'h25: ch = 8'h34;  8'h2E: ch = 8'h35;  8'h36: ch = 8'h36;  8'h3D: ch = 8'h37;
      8'h3E: ch = 8'h38;  8'h46: ch = 8'h39;  8'h29: ch = 8'h20;
      default: begin ch = 8'h00; ok = 1'b0; end
    endcase
    if (upper && ch >= 8'h61 && ch <= 8'h7A) ch = ch - 8'h20;
    to_ascii = {ok, ch};
  endfunction

  // Prefix parser: E0 marks extended, F0 marks break, anything else completes a code
  always_comb begin
    state_d = state_q;
    mk      = 1'b0;
    bk      = 1'b0;
    ext_c   = 1'b0;
    if (bus.byte_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.byte_data == 8'hE0)      state_d = EXT;
          else if (bus.byte_data == 8'hF0) state_d = BRK;
          else begin mk = 1'b1; state_d = IDLE; end
        end
        EXT: begin
          if (bus.byte_data == 8'hE0)      state_d = EXT;
          else if (bus.byte_data == 8'hF0) state_d = EXT_BRK;
          else begin mk = 1'b1; ext_c = 1'b1; state_d = IDLE; end
        end
        BRK: begin
          if (bus.byte_data != 8'hE0 && bus.byte_data != 8'hF0) begin
            bk = 1'b1; state_d = IDLE;
          end
        end
        default: begin
          if (bus.byte_data != 8'hE0 && bus.byte_data != 8'hF0) begin
            bk = 1'b1; ext_c = 1'b1; state_d = IDLE;
          end
        end
      endcase
    end
  end

  assign same_key = held_q && (ext_q == ext_c) && (code_q == bus.byte_data);
  assign map      = to_ascii(bus.byte_data, bus.shift ^ bus.caps);

  // Held-key tracking: new makes latch and count, repeats do nothing, matching breaks release
  always_comb begin
    held_d      = held_q;
    ext_d       = ext_q;
    code_d      = code_q;
    ascii_d     = ascii_q;
    ascii_vld_d = ascii_vld_q;
    count_d     = count_q;
    if (mk && !same_key) begin
      held_d      = 1'b1;
      ext_d       = ext_c;
      code_d      = bus.byte_data;
      ascii_d     = map[7:0];
      ascii_vld_d = map[8] && !ext_c;
      count_d     = count_q + 8'd1;
    end else if (bk && same_key) begin
      held_d = 1'b0;
    end
  end

  // Digit patterns from next-state values so the display tracks with one cycle latency
  always_comb begin
    seg_d[0] = held_d ? hex7(code_d[3:0]) : 8'hFF;
    seg_d[1] = held_d ? hex7(code_d[7:4]) : 8'hFF;
    seg_d[2] = (held_d && ascii_vld_d) ? hex7(ascii_d[3:0]) : 8'hFF;
    seg_d[3] = (held_d && ascii_vld_d) ? hex7(ascii_d[7:4]) : 8'hFF;
    seg_d[4] = hex7(count_d[3:0]);
    seg_d[5] = hex7(count_d[7:4]);
    seg_d[6] = 8'hFF;
    seg_d[7] = 8'hFF;
  end

  // Control state and segment registers; reset wins over a coincident byte
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= 8'h00;
      held_q   <= 1'b0;
      seg_q[0] <= 8'hFF;
      seg_q[1] <= 8'hFF;
      seg_q[2] <= 8'hFF;
      seg_q[3] <= 8'hFF;
      seg_q[4] <= 8'hC0;
      seg_q[5] <= 8'hC0;
      seg_q[6] <= 8'hFF;
      seg_q[7] <= 8'hFF;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      held_q  <= held_d;
      for (int i = 0; i < 8; i++) seg_q[i] <= seg_d[i];
    end
  end

  // Key payload; only meaningful while held_q is set, so it needs no reset
  always_ff @(posedge clk) begin
    ext_q       <= ext_d;
    code_q      <= code_d;
    ascii_q     <= ascii_d;
    ascii_vld_q <= ascii_vld_d;
  end

  assign bus.seg0 = seg_q[0];
  assign bus.seg1 = seg_q[1];
  assign bus.seg2 = seg_q[2];
  assign bus.seg3 = seg_q[3];
  assign bus.seg4 = seg_q[4];
  assign bus.seg5 = seg_q[5];
  assign bus.seg6 = seg_q[6];
  assign bus.seg7 = seg_q[7];
endmodule

// File: tb/tb_kb_seg_display.sv
// Directed bench for kb_seg_display. Each expected value is written as {seg7..seg0}.
module tb_kb_seg_display;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  logic [63:0] segs;

  kb_seg_display_if bus();

  kb_seg_display dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign segs = {bus.seg7, bus.seg6, bus.seg5, bus.seg4,
                 bus.seg3, bus.seg2, bus.seg1, bus.seg0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic burst3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = a;
    @(negedge clk);
    bus.byte_data  = b;
    @(negedge clk);
    bus.byte_data  = c;
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h1C;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    n_chk++;
    if (segs !== 64'hFFFF_C0C0_FFFF_FFFF) begin
      n_fail++; $display("FAIL reset_with_valid: got %h want %h", segs, 64'hFFFF_C0C0_FFFF_FFFF);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (segs !== 64'hFFFF_C0C0_FFFF_FFFF) begin
      n_fail++; $display("FAIL reset_idle: got %h want %h", segs, 64'hFFFF_C0C0_FFFF_FFFF);
    end
  endtask

  task automatic test_make_break();
    send(8'h1C);
    n_chk++;
    if (segs !== 64'hFFFF_C0F9_82F9_F9C6) begin
      n_fail++; $display("FAIL make_1C: got %h want %h", segs, 64'hFFFF_C0F9_82F9_F9C6);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (segs !== 64'hFFFF_C0F9_82F9_F9C6) begin
      n_fail++; $display("FAIL idle_hold: got %h want %h", segs, 64'hFFFF_C0F9_82F9_F9C6);
    end
    send(8'hF0);
    n_chk++;
    if (segs !== 64'hFFFF_C0F9_82F9_F9C6) begin
      n_fail++; $display("FAIL f0_pending: got %h want %h", segs, 64'hFFFF_C0F9_82F9_F9C6);
    end
    send(8'h1C);
    n_chk++;
    if (segs !== 64'hFFFF_C0F9_FFFF_FFFF) begin
      n_fail++; $display("FAIL break_1C: got %h want %h", segs, 64'hFFFF_C0F9_FFFF_FFFF);
    end
  endtask

  task automatic test_case();
    bus.caps = 1'b1;
    send(8'h1C);
    n_chk++;
    if (segs !== 64'hFFFF_C0A4_99F9_F9C6) begin
      n_fail++; $display("FAIL caps_upper: got %h want %h", segs, 64'hFFFF_C0A4_99F9_F9C6);
    end
    @(negedge clk);
    bus.caps = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (segs !== 64'hFFFF_C0A4_99F9_F9C6) begin
      n_fail++; $display("FAIL ascii_latched: got %h want %h", segs, 64'hFFFF_C0A4_99F9_F9C6);
    end
    send(8'hF0);
    send(8'h1C);
    bus.shift = 1'b1;
    bus.caps  = 1'b1;
    send(8'h1C);
    n_chk++;
    if (segs !== 64'hFFFF_C0B0_82F9_F9C6) begin
      n_fail++; $display("FAIL shift_caps_lower: got %h want %h", segs, 64'hFFFF_C0B0_82F9_F9C6);
    end
    send(8'hF0);
    send(8'h1C);
    bus.shift = 1'b0;
    bus.caps  = 1'b0;
  endtask

  task automatic test_repeat();
    send(8'h1C);
    send(8'h1C);
    send(8'h1C);
    n_chk++;
    if (segs !== 64'hFFFF_C099_82F9_F9C6) begin
      n_fail++; $display("FAIL typematic: got %h want %h", segs, 64'hFFFF_C099_82F9_F9C6);
    end
    send(8'hF0);
    send(8'h32);
    n_chk++;
    if (segs !== 64'hFFFF_C099_82F9_F9C6) begin
      n_fail++; $display("FAIL unheld_break: got %h want %h", segs, 64'hFFFF_C099_82F9_F9C6);
    end
    send(8'hF0);
    send(8'h1C);
    n_chk++;
    if (segs !== 64'hFFFF_C099_FFFF_FFFF) begin
      n_fail++; $display("FAIL release_after_repeat: got %h want %h", segs, 64'hFFFF_C099_FFFF_FFFF);
    end
  endtask

  task automatic test_ext();
    send(8'hE0);
    send(8'h75);
    n_chk++;
    if (segs !== 64'hFFFF_C092_FFFF_F892) begin
      n_fail++; $display("FAIL ext_make: got %h want %h", segs, 64'hFFFF_C092_FFFF_F892);
    end
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    n_chk++;
    if (segs !== 64'hFFFF_C092_FFFF_FFFF) begin
      n_fail++; $display("FAIL ext_break: got %h want %h", segs, 64'hFFFF_C092_FFFF_FFFF);
    end
    send(8'hE0);
    send(8'h75);
    send(8'hF0);
    send(8'h75);
    n_chk++;
    if (segs !== 64'hFFFF_C082_FFFF_F892) begin
      n_fail++; $display("FAIL nonext_break_ignored: got %h want %h", segs, 64'hFFFF_C082_FFFF_F892);
    end
    send(8'hE0);
    send(8'hF0);
    send(8'hE0);
    send(8'h75);
    n_chk++;
    if (segs !== 64'hFFFF_C082_FFFF_FFFF) begin
      n_fail++; $display("FAIL e0_in_ext_brk: got %h want %h", segs, 64'hFFFF_C082_FFFF_FFFF);
    end
    send(8'hE0);
    send(8'hE0);
    send(8'h75);
    n_chk++;
    if (segs !== 64'hFFFF_C0F8_FFFF_F892) begin
      n_fail++; $display("FAIL e0_e0_make: got %h want %h", segs, 64'hFFFF_C0F8_FFFF_F892);
    end
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
  endtask

  task automatic test_mapping();
    bus.shift = 1'b1;
    send(8'h45);
    n_chk++;
    if (segs !== 64'hFFFF_C080_B0C0_9992) begin
      n_fail++; $display("FAIL digit_shift: got %h want %h", segs, 64'hFFFF_C080_B0C0_9992);
    end
    send(8'hF0);
    send(8'h45);
    bus.shift = 1'b0;
    send(8'h05);
    n_chk++;
    if (segs !== 64'hFFFF_C090_FFFF_C092) begin
      n_fail++; $display("FAIL unmapped: got %h want %h", segs, 64'hFFFF_C090_FFFF_C092);
    end
    send(8'h1C);
    n_chk++;
    if (segs !== 64'hFFFF_C088_82F9_F9C6) begin
      n_fail++; $display("FAIL new_key_while_held: got %h want %h", segs, 64'hFFFF_C088_82F9_F9C6);
    end
    send(8'hF0);
    send(8'h05);
    n_chk++;
    if (segs !== 64'hFFFF_C088_82F9_F9C6) begin
      n_fail++; $display("FAIL old_key_break: got %h want %h", segs, 64'hFFFF_C088_82F9_F9C6);
    end
    send(8'hF0);
    send(8'h1C);
    n_chk++;
    if (segs !== 64'hFFFF_C088_FFFF_FFFF) begin
      n_fail++; $display("FAIL final_release: got %h want %h", segs, 64'hFFFF_C088_FFFF_FFFF);
    end
  endtask

  task automatic test_wrap();
    pulse_reset();
    for (int i = 0; i < 256; i++) begin
      send(8'h1C);
      if (i == 254) begin
        n_chk++;
        if (segs !== 64'hFFFF_8E8E_82F9_F9C6) begin
          n_fail++; $display("FAIL count_ff: got %h want %h", segs, 64'hFFFF_8E8E_82F9_F9C6);
        end
      end
      send(8'hF0);
      send(8'h1C);
    end
    n_chk++;
    if (segs !== 64'hFFFF_C0C0_FFFF_FFFF) begin
      n_fail++; $display("FAIL count_wrap: got %h want %h", segs, 64'hFFFF_C0C0_FFFF_FFFF);
    end
  endtask

  task automatic test_reset_mid();
    send(8'hE0);
    pulse_reset();
    n_chk++;
    if (segs !== 64'hFFFF_C0C0_FFFF_FFFF) begin
      n_fail++; $display("FAIL reset_mid_e0: got %h want %h", segs, 64'hFFFF_C0C0_FFFF_FFFF);
    end
    send(8'h75);
    n_chk++;
    if (segs !== 64'hFFFF_C0F9_FFFF_F892) begin
      n_fail++; $display("FAIL e0_discarded: got %h want %h", segs, 64'hFFFF_C0F9_FFFF_F892);
    end
    send(8'hF0);
    send(8'h75);
    n_chk++;
    if (segs !== 64'hFFFF_C0F9_FFFF_FFFF) begin
      n_fail++; $display("FAIL nonext_release: got %h want %h", segs, 64'hFFFF_C0F9_FFFF_FFFF);
    end
    send(8'h1C);
    send(8'hF0);
    pulse_reset();
    send(8'h1C);
    n_chk++;
    if (segs !== 64'hFFFF_C0F9_82F9_F9C6) begin
      n_fail++; $display("FAIL f0_discarded: got %h want %h", segs, 64'hFFFF_C0F9_82F9_F9C6);
    end
  endtask

  task automatic test_back_to_back();
    burst3(8'hF0, 8'h1C, 8'h32);
    n_chk++;
    if (segs !== 64'hFFFF_C0A4_82A4_B0A4) begin
      n_fail++; $display("FAIL burst_release_press: got %h want %h", segs, 64'hFFFF_C0A4_82A4_B0A4);
    end
    burst3(8'hF0, 8'h32, 8'hE0);
    send(8'h75);
    n_chk++;
    if (segs !== 64'hFFFF_C0B0_FFFF_F892) begin
      n_fail++; $display("FAIL burst_ext: got %h want %h", segs, 64'hFFFF_C0B0_FFFF_F892);
    end
  endtask

  initial begin
    n_chk          = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.shift      = 1'b0;
    bus.caps       = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_make_break();
    test_case();
    test_repeat();
    test_ext();
    test_mapping();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
